multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the 16-bit CR16-style CPU. Latches the fetched instruction, decodes

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/cond_eval.sv | 37 +++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared control definitions for the CR16-style multicycle CPU:
// FSM states, opcode/opext values, datapath select encodings, branch conditions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_SPEC  = 4'b0100;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic       MEM_PC    = 1'b0;
  localparam logic       MEM_RSRC  = 1'b1;
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_ALU    = 2'b01;
  localparam logic [1:0] PC_RSRC   = 2'b10;
  localparam logic [1:0] ALUA_PC   = 2'b00;
  localparam logic [1:0] ALUA_RDST = 2'b10;
  localparam logic       ALUB_RSRC = 1'b0;
  localparam logic       ALUB_IMM  = 1'b1;
  localparam logic       WA_RSRC   = 1'b0;
  localparam logic       WA_RDEST  = 1'b1;
  localparam logic [1:0] WD_MEM    = 2'b00;
  localparam logic [1:0] WD_PC1    = 2'b01;
  localparam logic [1:0] WD_IMM    = 2'b10;
  localparam logic [1:0] WD_ALU    = 2'b11;

  localparam logic [3:0] C_EQ = 4'b0000;
  localparam logic [3:0] C_NE = 4'b0001;
  localparam logic [3:0] C_CS = 4'b0010;
  localparam logic [3:0] C_CC = 4'b0011;
  localparam logic [3:0] C_HI = 4'b0100;
  localparam logic [3:0] C_LS = 4'b0101;
  localparam logic [3:0] C_GT = 4'b0110;
  localparam logic [3:0] C_LE = 4'b0111;
  localparam logic [3:0] C_FS = 4'b1000;
  localparam logic [3:0] C_FC = 4'b1001;
  localparam logic [3:0] C_LO = 4'b1010;
  localparam logic [3:0] C_HS = 4'b1011;
  localparam logic [3:0] C_LT = 4'b1100;
  localparam logic [3:0] C_GE = 4'b1101;
  localparam logic [3:0] C_UC = 4'b1110;
  localparam logic [3:0] C_NV = 4'b1111;

  // Logical immediates take a zero-extended operand.
  function automatic logic is_logic_imm(
    input logic [3:0] op
  );
    return (op == OP_ANDI) ||
           (op == OP_ORI)  ||
           (op == OP_XORI);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator.
// cond: IR[11:8] code; flags: PSR {F,L,N,C,Z}; cond_ok: condition holds.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_ok
);

  logic f, l, n, c, z;

  assign {f, l, n, c, z} = flags;

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      C_EQ: cond_ok = z;
      C_NE: cond_ok = !z;
      C_CS: cond_ok = c;
      C_CC: cond_ok = !c;
      C_HI: cond_ok = l;
      C_LS: cond_ok = !l;
      C_GT: cond_ok = n;
      C_LE: cond_ok = !n;
      C_FS: cond_ok = f;
      C_FC: cond_ok = !f;
      C_LO: cond_ok = !l && !z;
      C_HS: cond_ok = l || z;
      C_LT: cond_ok = !n && !z;
      C_GE: cond_ok = n || z;
      C_UC: cond_ok = 1'b1;
      C_NV: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode, memory handshake, branch/jump, retire count.
// In: clk, reset, mem_rdata, mem_ready, flags. Out: memory req, datapath selects, IR fields, retired.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int IMM     = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ready,
  input  logic [4:0]         flags,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_s,
  output logic               pcen,
  output logic [1:0]         pc_s,
  output logic [1:0]         alua_s,
  output logic               alub_s,
  output logic               signext_sign,
  output logic               wa_s,
  output logic [1:0]         wd_s,
  output logic               regwrite,
  output logic [3:0]         opcode,
  output logic [3:0]         opext,
  output logic [REGBITS-1:0] rdest_addr,
  output logic [REGBITS-1:0] rsrc_addr,
  output logic [IMM-1:0]     imm,
  output logic [CNT_W-1:0]   retired
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] ir;
  logic             cond_ok;
  logic             retire;

  logic is_rtype, is_spec, is_bcond, is_movi;
  logic is_load, is_stor, is_jal, is_jcond;
  logic is_alu, is_cmp;

  assign opcode     = ir[15:12];
  assign rdest_addr = ir[11:8];
  assign opext      = ir[7:4];
  assign rsrc_addr  = ir[3:0];
  assign imm        = ir[IMM-1:0];

  assign is_rtype = opcode == OP_RTYPE;
  assign is_spec  = opcode == OP_SPEC;
  assign is_bcond = opcode == OP_BCOND;
  assign is_movi  = opcode == OP_MOVI;
  assign is_load  = is_spec && opext == EXT_LOAD;
  assign is_stor  = is_spec && opext == EXT_STOR;
  assign is_jal   = is_spec && opext == EXT_JAL;
  assign is_jcond = is_spec && opext == EXT_JCOND;
  assign is_alu   = !is_spec && !is_bcond;
  assign is_cmp   = (is_rtype && opext == EXT_CMP) ||
                    opcode == OP_CMPI;

  cond_eval u_cond (
    .cond    (ir[11:8]),
    .flags   (flags),
    .cond_ok (cond_ok)
  );

  always_comb begin
    state_n      = state;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_s        = MEM_PC;
    pcen         = 1'b0;
    pc_s         = PC_INC;
    alua_s       = ALUA_PC;
    alub_s       = ALUB_RSRC;
    signext_sign = 1'b0;
    wa_s         = WA_RSRC;
    wd_s         = WD_MEM;
    regwrite     = 1'b0;
    unique case (state)
      S_FETCH: begin
        // Reset forces FETCH; gating keeps the request low meanwhile.
        mem_req = !reset;
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_load:            state_n = S_MEM_RD;
          is_stor:            state_n = S_MEM_WR;
          is_jal || is_jcond: state_n = S_JUMP;
          is_bcond:           state_n = S_BRANCH;
          is_alu:             state_n = S_EXEC;
          default:            state_n = S_WB;
        endcase
      end
      S_EXEC: begin
        alua_s       = ALUA_RDST;
        alub_s       = is_rtype ? ALUB_RSRC : ALUB_IMM;
        signext_sign = !is_logic_imm(opcode);
        regwrite     = !is_cmp;
        wd_s         = is_movi ? WD_IMM : WD_ALU;
        wa_s         = WA_RDEST;
        state_n      = S_WB;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        mem_s   = MEM_RSRC;
        wa_s    = WA_RDEST;
        wd_s    = WD_MEM;
        if (mem_ready) begin
          regwrite = 1'b1;
          state_n  = S_WB;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mem_s   = MEM_RSRC;
        if (mem_ready) state_n = S_WB;
      end
      S_BRANCH: begin
        alua_s       = ALUA_PC;
        alub_s       = ALUB_IMM;
        signext_sign = 1'b1;
        pc_s         = PC_ALU;
        pcen         = cond_ok;
        // Taken branch retires here; otherwise WB does the PC+1.
        state_n      = cond_ok ? S_FETCH : S_WB;
        retire       = cond_ok;
      end
      S_JUMP: begin
        pc_s = PC_RSRC;
        if (is_jal) begin
          pcen     = 1'b1;
          regwrite = 1'b1;
          wd_s     = WD_PC1;
          wa_s     = WA_RDEST;
          state_n  = S_FETCH;
          retire   = 1'b1;
        end else begin
          pcen    = cond_ok;
          state_n = cond_ok ? S_FETCH : S_WB;
          retire  = cond_ok;
        end
      end
      S_WB: begin
        pcen    = 1'b1;
        pc_s    = PC_INC;
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == S_FETCH && mem_ready)
        ir <= mem_rdata;
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Per-cycle stimulus queue; expected controls pushed to a scoreboard on drive.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [4:0]  flags = '0;
  logic        mem_req, mem_we, mem_s, pcen;
  logic [1:0]  pc_s, alua_s, wd_s;
  logic        alub_s, signext_sign, wa_s, regwrite;
  logic [3:0]  opcode, opext, rdest_addr, rsrc_addr;
  logic [7:0]  imm;
  logic [15:0] retired;
  logic [13:0] ctl;
  logic [23:0] fields;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .flags        (flags),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_s        (mem_s),
    .pcen         (pcen),
    .pc_s         (pc_s),
    .alua_s       (alua_s),
    .alub_s       (alub_s),
    .signext_sign (signext_sign),
    .wa_s         (wa_s),
    .wd_s         (wd_s),
    .regwrite     (regwrite),
    .opcode       (opcode),
    .opext        (opext),
    .rdest_addr   (rdest_addr),
    .rsrc_addr    (rsrc_addr),
    .imm          (imm),
    .retired      (retired)
  );

  // {mem_req,mem_we,mem_s,pcen,pc_s,alua_s,alub_s,sx,wa_s,wd_s,regwrite}
  assign ctl = {mem_req, mem_we, mem_s, pcen, pc_s, alua_s,
                alub_s, signext_sign, wa_s, wd_s, regwrite};
  assign fields = {opcode, rdest_addr, opext, rsrc_addr, imm};

  localparam logic [13:0] C_FETCH = 14'h2000;
  localparam logic [13:0] C_WB    = 14'h0400;
  localparam logic [13:0] M_ALL   = 14'h3FFF;
  localparam logic [13:0] M_NSX   = 14'h3FEF;
  localparam logic [13:0] M_NWA   = 14'h3FF7;

  typedef struct {
    logic        rdy;
    logic [15:0] rd;
    logic [4:0]  fl;
    logic [13:0] ctl;
    logic [13:0] msk;
    logic [15:0] ret;
    string       tag;
  } vec_t;

  typedef struct {
    logic [13:0] ctl;
    logic [13:0] msk;
    logic [15:0] ret;
    string       tag;
  } exp_t;

  vec_t        st[$];
  exp_t        sb[$];
  int          vecs = 0;
  int          bad = 0;
  logic [15:0] ret_m = '0;

  task automatic push(input logic rdy, input logic [15:0] rd,
                      input logic [4:0] fl, input logic [13:0] c,
                      input logic [13:0] m, input string tag);
    vec_t v;
    v.rdy = rdy; v.rd = rd; v.fl = fl;
    v.ctl = c; v.msk = m; v.ret = ret_m; v.tag = tag;
    st.push_back(v);
  endtask

  task automatic apply();
    vec_t v;
    exp_t e;
    @(negedge clk);
    v = st.pop_front();
    mem_ready = v.rdy;
    mem_rdata = v.rd;
    flags = v.fl;
    e.ctl = v.ctl; e.msk = v.msk; e.ret = v.ret; e.tag = v.tag;
    sb.push_back(e);
  endtask

  function automatic logic cond_ref(input logic [3:0] c,
                                    input logic [4:0] f);
    logic ff, fl, fn, fc, fz;
    {ff, fl, fn, fc, fz} = f;
    case (c)
      4'h0: return fz;        4'h1: return !fz;
      4'h2: return fc;        4'h3: return !fc;
      4'h4: return fl;        4'h5: return !fl;
      4'h6: return fn;        4'h7: return !fn;
      4'h8: return ff;        4'h9: return !ff;
      4'hA: return !fl && !fz; 4'hB: return fl || fz;
      4'hC: return !fn && !fz; 4'hD: return fn || fz;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    vecs++;
    if (ctl !== '0 || retired !== '0 || fields !== '0) begin
      bad++;
      $display("FAIL reset: ctl=%h ret=%0d f=%h, want 0", ctl, retired, fields);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    exp_t e;
    push(1, 16'h0251, 0, C_FETCH, M_ALL, "add.fetch");
    push(1, 16'h0000, 0, 14'h000, M_ALL, "add.decode");
    push(1, 16'h0000, 0, 14'h08F, M_NSX, "add.exec");
    push(1, 16'h0000, 0, C_WB,    M_ALL, "add.wb");
    ret_m++;
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
    vecs++;
    if (fields !== 24'h025151) begin
      bad++;
      $display("FAIL add.fields: got %h want 025151", fields);
    end
  endtask

  task automatic test_fetch_wait();
    exp_t e;
    for (int i = 0; i < 3; i++)
      push(0, 16'hFFFF, 0, C_FETCH, M_ALL, "wait.fetch");
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
    vecs++;
    if (fields !== 24'h025151) begin
      bad++;
      $display("FAIL wait.ir_held: got %h want 025151", fields);
    end
  endtask

  task automatic test_movi();
    exp_t e;
    push(1, 16'hD3A5, 0, C_FETCH, M_ALL, "movi.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "movi.decode");
    push(0, 16'h0000, 0, 14'h0AD, M_NSX, "movi.exec");
    push(0, 16'h0000, 0, C_WB,    M_ALL, "movi.wb");
    ret_m++;
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
    vecs++;
    if (fields !== 24'hD3A5A5) begin
      bad++;
      $display("FAIL movi.fields: got %h want d3a5a5", fields);
    end
  endtask

  task automatic test_imm_alu();
    exp_t e;
    // ANDI zero-extends, ADDI sign-extends, CMP writes nothing
    push(1, 16'h13F0, 0, C_FETCH, M_ALL, "andi.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "andi.decode");
    push(0, 16'h0000, 0, 14'h0AF, M_ALL, "andi.exec");
    push(0, 16'h0000, 0, C_WB,    M_ALL, "andi.wb");
    ret_m++;
    push(1, 16'h5205, 0, C_FETCH, M_ALL, "addi.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "addi.decode");
    push(0, 16'h0000, 0, 14'h0BF, M_ALL, "addi.exec");
    push(0, 16'h0000, 0, C_WB,    M_ALL, "addi.wb");
    ret_m++;
    push(1, 16'h02B1, 0, C_FETCH, M_ALL, "cmp.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "cmp.decode");
    push(0, 16'h0000, 0, 14'h08E, M_NSX, "cmp.exec");
    push(0, 16'h0000, 0, C_WB,    M_ALL, "cmp.wb");
    ret_m++;
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    push(1, 16'hC0FC, 5'h01, C_FETCH, M_ALL, "beq_t.fetch");
    push(0, 16'h0000, 5'h01, 14'h000, M_ALL, "beq_t.decode");
    push(0, 16'h0000, 5'h01, 14'h530, M_ALL, "beq_t.branch");
    ret_m++;
    push(1, 16'hC0FC, 5'h00, C_FETCH, M_ALL, "beq_n.fetch");
    push(0, 16'h0000, 5'h00, 14'h000, M_ALL, "beq_n.decode");
    push(0, 16'h0000, 5'h00, 14'h130, M_ALL, "beq_n.branch");
    push(0, 16'h0000, 5'h00, C_WB,    M_ALL, "beq_n.wb");
    ret_m++;
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
    vecs++;
    if (imm !== 8'hFC) begin
      bad++;
      $display("FAIL beq.imm: got %h want fc", imm);
    end
  endtask

  task automatic test_conds();
    exp_t        e;
    logic [4:0]  f;
    logic        tk;
    logic [15:0] ins;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 3; k++) begin
        f = (k == 0) ? 5'h00 : (k == 1) ? 5'h1F : 5'($urandom_range(0, 31));
        tk = cond_ref(4'(c), f);
        ins = {4'hC, 4'(c), 8'h02};
        push(1, ins, f, C_FETCH, M_ALL, "cond.fetch");
        push(0, 16'h0000, f, 14'h000, M_ALL, "cond.decode");
        push(0, 16'h0000, f, tk ? 14'h530 : 14'h130, M_ALL, "cond.branch");
        if (!tk) push(0, 16'h0000, f, C_WB, M_ALL, "cond.wb");
        ret_m++;
      end
    end
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s c=%h fl=%h: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, rdest_addr, flags, ctl & e.msk, retired,
                 e.ctl & e.msk, e.ret);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    push(1, 16'h4305, 0, C_FETCH, M_ALL, "ld.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "ld.decode");
    push(0, 16'h0000, 0, 14'h2800, M_NWA, "ld.wait1");
    push(0, 16'h0000, 0, 14'h2800, M_NWA, "ld.wait2");
    push(1, 16'h1234, 0, 14'h2801, M_NWA, "ld.ready");
    push(0, 16'h0000, 0, C_WB,    M_ALL, "ld.wb");
    ret_m++;
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    push(1, 16'h4E86, 0, C_FETCH, M_ALL, "jal.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "jal.decode");
    push(0, 16'h0000, 0, 14'h60B, M_ALL, "jal.jump");
    ret_m++;
    push(1, 16'h4FC6, 5'h1F, C_FETCH, M_ALL, "jnv.fetch");
    push(0, 16'h0000, 5'h1F, 14'h000, M_ALL, "jnv.decode");
    push(0, 16'h0000, 5'h1F, 14'h200, M_NWA, "jnv.jump");
    push(0, 16'h0000, 5'h1F, C_WB,    M_ALL, "jnv.wb");
    ret_m++;
    push(1, 16'h40C6, 5'h01, C_FETCH, M_ALL, "jeq.fetch");
    push(0, 16'h0000, 5'h01, 14'h000, M_ALL, "jeq.decode");
    push(0, 16'h0000, 5'h01, 14'h600, M_NWA, "jeq.jump");
    ret_m++;
    push(0, 16'h0000, 5'h00, C_FETCH, M_ALL, "jeq.next");
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    exp_t e;
    push(1, 16'h4345, 0, C_FETCH, M_ALL, "st.fetch");
    push(0, 16'h0000, 0, 14'h000, M_ALL, "st.decode");
    push(0, 16'h0000, 0, 14'h3800, M_ALL, "st.wait");
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (ctl !== '0 || retired !== '0 || fields !== '0) begin
      bad++;
      $display("FAIL rst.async: ctl=%h ret=%0d f=%h, want 0", ctl, retired, fields);
    end
    @(negedge clk);
    reset = 1'b0;
    ret_m = '0;
    push(0, 16'h0000, 0, C_FETCH, M_ALL, "rst.fetch");
    while (st.size() > 0) begin
      apply(); #1; e = sb.pop_front(); vecs++;
      if ((ctl & e.msk) !== (e.ctl & e.msk) || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%h ret=%0d, want ctl=%h ret=%0d",
                 e.tag, ctl & e.msk, retired, e.ctl & e.msk, e.ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fetch_wait();
    test_movi();
    test_imm_alu();
    test_branch();
    test_conds();
    test_load();
    test_jump();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
